// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the 8-bit Fibonacci LFSR stream. It predicts each
// sample from the previous one using the configured tap mask, acquires lock
// after LOCK_COUNT consecutive predicted matches, and counts mismatches while
// locked. Isolated errors are bridged by a flywheel predictor. Lock is dropped
// after LOSS_COUNT consecutive misses. Invalid length/tap combinations are
// flagged on cfg_bad.
//
// Optional feature: define LFSR_CHECKER_PERIOD_EN to add the period/
// period_valid outputs, which measure the stream period while locked.
//
// Input strobe: rx_value is consumed on a rising edge only when rx_valid=1.
// There is no back-pressure; the checker accepts every strobed sample.
//
// All outputs are registered; each response appears on the cycle after the
// sample or configuration event that causes it. dbg_state mirrors the FSM
// state (0=BAD, 1=HUNT, 2=LOCKED).
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cfg_length,
  input  logic             cfg_n_taps,
  input  logic [7:0]       rx_value,
  input  logic             rx_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             cfg_bad,
`ifdef LFSR_CHECKER_PERIOD_EN
  output logic [7:0]       period,
  output logic             period_valid,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_BAD    = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // Registered state
  state_t           state_q;
  logic [7:0]       prev_q;
  logic             have_prev_q;
  logic [3:0]       match_streak_q;
  logic [3:0]       miss_streak_q;
  logic [2:0]       cfg_len_q;
  logic             cfg_taps_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             cfg_bad_q;
  logic [ERR_W-1:0] err_count_q;

  // Combinational helpers
  logic [7:0] mask;
  logic       mask_ok;
  logic [7:0] pred;
  logic       cfg_changed;
  logic       sample_en;
  logic       hunt_match;
  logic       locked_match;
  logic [3:0] match_next;
  logic [3:0] miss_next;
  logic       hunt_lock;
  logic       lock_sample;
  logic       lock_err;
  logic       lock_lost;
  logic       err_sat;

  // Decode the tap mask; a zero mask marks an unsupported combination
  always_comb begin
    mask = 8'h00;
    if (!cfg_n_taps) begin
      case (cfg_length)
        3'd2:    mask = 8'h03;
        3'd3:    mask = 8'h06;
        3'd4:    mask = 8'h0C;
        3'd5:    mask = 8'h14;
        3'd6:    mask = 8'h30;
        3'd7:    mask = 8'h60;
        default: mask = 8'h00;
      endcase
    end else begin
      case (cfg_length)
        3'd5:    mask = 8'h1E;
        3'd6:    mask = 8'h36;
        3'd7:    mask = 8'h78;
        default: mask = 8'h00;
      endcase
    end
    mask_ok = (mask != 8'h00);
  end

  // Prediction and the per-cycle decision terms shared by all register blocks
  always_comb begin
    pred         = {prev_q[6:0], ^(prev_q & mask)};
    cfg_changed  = (cfg_length != cfg_len_q) || (cfg_n_taps != cfg_taps_q);
    // A sample is consumed only when no higher-priority config event applies
    sample_en    = mask_ok && (state_q != ST_BAD) && !cfg_changed && rx_valid;
    hunt_match   = have_prev_q && (rx_value == pred) && (rx_value != 8'h00);
    // All-zero is the LFSR lock-up value and never counts as a good sample
    locked_match = (rx_value == pred) && (rx_value != 8'h00);
    match_next   = match_streak_q + 4'd1;
    miss_next    = miss_streak_q + 4'd1;
    hunt_lock    = sample_en && (state_q == ST_HUNT) && hunt_match &&
                   (match_next == LOCK_CNT);
    lock_sample  = sample_en && (state_q == ST_LOCKED);
    lock_err     = lock_sample && !locked_match;
    lock_lost    = lock_err && (miss_next == LOSS_CNT);
    err_sat      = &err_count_q;
  end

  // Main BAD/HUNT/LOCKED state machine with its registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BAD;
      prev_q         <= 8'h00;
      have_prev_q    <= 1'b0;
      match_streak_q <= 4'd0;
      miss_streak_q  <= 4'd0;
      cfg_len_q      <= 3'd0;
      cfg_taps_q     <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      cfg_bad_q      <= 1'b1;
    end else begin
      cfg_len_q   <= cfg_length;
      cfg_taps_q  <= cfg_n_taps;
      cfg_bad_q   <= !mask_ok;
      err_pulse_q <= lock_err;

      if (!mask_ok) begin
        state_q        <= ST_BAD;
        locked_q       <= 1'b0;
        have_prev_q    <= 1'b0;
        match_streak_q <= 4'd0;
        miss_streak_q  <= 4'd0;
      end else if (state_q == ST_BAD) begin
        state_q        <= ST_HUNT;
        locked_q       <= 1'b0;
        have_prev_q    <= 1'b0;
        match_streak_q <= 4'd0;
        miss_streak_q  <= 4'd0;
      end else if (cfg_changed) begin
        // A new configuration invalidates any history, even mid-lock
        state_q        <= ST_HUNT;
        locked_q       <= 1'b0;
        have_prev_q    <= 1'b0;
        match_streak_q <= 4'd0;
        miss_streak_q  <= 4'd0;
      end else if (rx_valid) begin
        case (state_q)
          ST_HUNT: begin
            prev_q      <= rx_value;
            have_prev_q <= 1'b1;
            if (hunt_lock) begin
              state_q        <= ST_LOCKED;
              locked_q       <= 1'b1;
              match_streak_q <= 4'd0;
              miss_streak_q  <= 4'd0;
            end else if (hunt_match) begin
              match_streak_q <= match_next;
            end else begin
              match_streak_q <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (locked_match) begin
              prev_q        <= rx_value;
              miss_streak_q <= 4'd0;
            end else if (lock_lost) begin
              // Sustained loss: resynchronise on the received value
              state_q        <= ST_HUNT;
              locked_q       <= 1'b0;
              prev_q         <= rx_value;
              have_prev_q    <= 1'b1;
              match_streak_q <= 4'd0;
              miss_streak_q  <= 4'd0;
            end else begin
              // Flywheel: keep following the predicted sequence
              prev_q        <= pred;
              miss_streak_q <= miss_next;
            end
          end
          default: begin
            state_q <= ST_HUNT;
          end
        endcase
      end
    end
  end

  // Saturating mismatch counter; clear wins over increment but still counts
  // a same-cycle error
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (clr_err) begin
      err_count_q <= lock_err ? ERR_ONE : '0;
    end else if (lock_err && !err_sat) begin
      err_count_q <= err_count_q + ERR_ONE;
    end
  end

`ifdef LFSR_CHECKER_PERIOD_EN
  logic [7:0] ref_val_q;
  logic [7:0] per_cnt_q;
  logic [7:0] period_q;
  logic       period_valid_q;
  logic       leave_lock;

  assign leave_lock = (state_q == ST_LOCKED) && (!mask_ok || cfg_changed || lock_lost);

  // Measure the distance between recurrences of the sample that achieved lock
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_val_q      <= 8'h00;
      per_cnt_q      <= 8'h00;
      period_q       <= 8'h00;
      period_valid_q <= 1'b0;
    end else if (hunt_lock) begin
      ref_val_q <= rx_value;
      per_cnt_q <= 8'h00;
    end else if (leave_lock) begin
      period_valid_q <= 1'b0;
    end else if (lock_sample) begin
      if (rx_value == ref_val_q) begin
        period_q       <= per_cnt_q + 8'd1;
        period_valid_q <= 1'b1;
        per_cnt_q      <= 8'h00;
      end else if (per_cnt_q == 8'd254) begin
        // No recurrence within 255 samples: report period 0
        period_q       <= 8'h00;
        period_valid_q <= 1'b1;
        per_cnt_q      <= 8'h00;
      end else begin
        per_cnt_q <= per_cnt_q + 8'd1;
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`endif

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign cfg_bad   = cfg_bad_q;
  assign dbg_state = state_q;

endmodule
